// File: rtl/regfile_loader.sv
// Register-file preload engine: holds the processor in reset, streams words into
// r START_REG..LAST_REG through the regfile write port, then hands the port back.
module regfile_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int START_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  proc_rwe,
  input  logic [4:0]            proc_rd,
  input  logic [DATA_WIDTH-1:0] proc_rData,
  output logic                  ctrl_writeEnable,
  output logic [4:0]            ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic                  proc_reset,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            load_ptr
);

  localparam logic [4:0] START_PTR = 5'(START_REG);
  localparam logic [4:0] LAST_PTR  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] load_ptr_next;

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      load_ptr   <= START_PTR;
      proc_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      load_ptr   <= load_ptr_next;
      proc_reset <= (state_next != RUN);
      busy       <= (state_next == LOAD) || (state_next == RELEASE);
      done       <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next       = state;
    load_ptr_next    = load_ptr;
    in_ready         = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;

    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ctrl_writeEnable = 1'b1;
          ctrl_writeReg    = load_ptr;
          data_writeReg    = in_data;
          if (load_ptr == LAST_PTR) state_next = RELEASE;
          else                      load_ptr_next = load_ptr + 5'd1;
        end
      end
      RELEASE: begin
        state_next = RUN;
      end
      RUN: begin
        ctrl_writeEnable = proc_rwe;
        ctrl_writeReg    = proc_rd;
        data_writeReg    = proc_rData;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // While reset is held nobody may write the regfile or hand us a word.
    if (!reset) begin
      in_ready         = 1'b0;
      ctrl_writeEnable = 1'b0;
    end
  end

endmodule
